// File: rtl/mul_sequencer_if.sv
// Execute-stage multiply handshake: operands and start/abort from the pipeline,
// stall/done strobes and the flagged result back.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Accumulate;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [WIDTH-1:0] Addend;
  logic             Abort;
  logic             StallMul;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             ResN;
  logic             ResZ;

  modport master (
    output Start, Accumulate, OpA, OpB, Addend, Abort,
    input  StallMul, Busy, Done, Result, ResN, ResZ
  );

  modport slave (
    input  Start, Accumulate, OpA, OpB, Addend, Abort,
    output StallMul, Busy, Done, Result, ResN, ResZ
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL/MLA: Done WIDTH/BPC+1 cycles after Start (+1 for MLA), fewer with EARLY_EXIT.
// Backpressure: stalls F/D/E from the accepting Start cycle until the DONE cycle; Abort returns to IDLE.
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter int BPC        = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, ACC, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] mA, mulB, p, addend, result;
  logic [WIDTH-1:0] partial, pNext, mANext, mulBNext;
  logic [CW-1:0]    cnt;
  logic             accFlag;
  logic             accept;
  logic             lastRun;

  // Partial product of the multiplicand with the low BPC multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mulB[i]) partial = partial + (mA << i);
    end
    pNext    = p + partial;
    mANext   = mA << BPC;
    mulBNext = mulB >> BPC;
    lastRun  = (cnt == '0) || ((EARLY_EXIT != 0) && (mulBNext == '0));
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (lastRun) stateNext = accFlag ? ACC : DONE;
      end
      ACC: stateNext = DONE;
      DONE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Abort outranks everything, including a same-cycle Start.
    if (bus.Abort) begin
      stateNext = IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mA      <= '0;
      mulB    <= '0;
      p       <= '0;
      addend  <= '0;
      accFlag <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        mA      <= bus.OpA;
        mulB    <= bus.OpB;
        addend  <= bus.Addend;
        accFlag <= bus.Accumulate;
        p       <= '0;
        cnt     <= CW'(N - 1);
      end else if (state == RUN && !bus.Abort) begin
        p    <= pNext;
        mA   <= mANext;
        mulB <= mulBNext;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == ACC && !bus.Abort) begin
        p <= p + addend;
      end
      // Result only moves on entry to DONE, so it holds across IDLE and aborts.
      if (stateNext == DONE) result <= (state == ACC) ? (p + addend) : pNext;
    end
  end

  assign bus.Busy     = (state == RUN) || (state == ACC);
  assign bus.Done     = (state == DONE);
  assign bus.StallMul = (((state == IDLE) || (state == DONE)) && bus.Start && !bus.Abort) || bus.Busy;
  assign bus.Result   = result;
  assign bus.ResN     = result[WIDTH-1];
  assign bus.ResZ     = (result == '0);
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one BPC=1 engine and one BPC=4 early-exit engine.
module tb_mul_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  mul_sequencer_if #(.WIDTH(32)) bus1();
  mul_sequencer_if #(.WIDTH(32)) bus2();

  mul_sequencer #(.WIDTH(32), .BPC(1), .EARLY_EXIT(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mul_sequencer #(.WIDTH(32), .BPC(4), .EARLY_EXIT(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        acc;
    logic [31:0] a, b, add, res;
    logic        n, z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, res;
    int          lat;
  } evec_t;

  vec_t  vecs[7];
  evec_t evecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp1(input logic acc, input logic [31:0] a, input logic [31:0] b, input logic [31:0] add);
    bus1.Start      = 1'b1;
    bus1.Accumulate = acc;
    bus1.OpA        = a;
    bus1.OpB        = b;
    bus1.Addend     = add;
  endtask

  // Called at posedge+1 of cycle 1; returns at the negedge of the Done cycle.
  task automatic waitDone1(output int lat, output logic stallOk);
    lat     = -1;
    stallOk = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus1.Done) begin
        lat = c;
        break;
      end
      if (!bus1.StallMul) stallOk = 1'b0;
      nextCycle();
    end
  endtask

  task automatic waitDone2(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus2.Done) begin
        lat = c;
        break;
      end
      nextCycle();
    end
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_stall1"}, 32'(bus1.StallMul), 32'd0);
    chk({tag, "_busy1"},  32'(bus1.Busy),     32'd0);
    chk({tag, "_done1"},  32'(bus1.Done),     32'd0);
    chk({tag, "_res1"},   bus1.Result,        32'd0);
    chk({tag, "_resn1"},  32'(bus1.ResN),     32'd0);
    chk({tag, "_resz1"},  32'(bus1.ResZ),     32'd1);
    chk({tag, "_busy2"},  32'(bus2.Busy),     32'd0);
    chk({tag, "_res2"},   bus2.Result,        32'd0);
    chk({tag, "_resn2"},  32'(bus2.ResN),     32'd0);
    chk({tag, "_resz2"},  32'(bus2.ResZ),     32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, lat2;
    logic ok;
    int   doneCnt;

    vecs[0] = '{1'b0, 32'd7,        32'd6,        32'd0,    32'd42,       1'b0, 1'b0, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'd2,        32'd3,    32'h00000001, 1'b0, 1'b0, 34};
    vecs[2] = '{1'b0, 32'h80000000, 32'd1,        32'd0,    32'h80000000, 1'b1, 1'b0, 33};
    vecs[3] = '{1'b0, 32'h00010000, 32'h00010000, 32'd0,    32'h00000000, 1'b0, 1'b1, 33};
    vecs[4] = '{1'b0, 32'd5,        32'd0,        32'd0,    32'h00000000, 1'b0, 1'b1, 33};
    vecs[5] = '{1'b1, 32'h12345678, 32'h10,       32'h11,   32'h23456791, 1'b0, 1'b0, 34};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,    32'h00000001, 1'b0, 1'b0, 33};

    evecs[0] = '{32'd7,  32'd0,        32'h00000000, 2};
    evecs[1] = '{32'h11, 32'd5,        32'h00000055, 2};
    evecs[2] = '{32'd3,  32'h100,      32'h00000300, 4};
    evecs[3] = '{32'd2,  32'hF0000000, 32'hE0000000, 9};

    bus1.Start = 1'b0; bus1.Accumulate = 1'b0; bus1.OpA = '0; bus1.OpB = '0; bus1.Addend = '0; bus1.Abort = 1'b0;
    bus2.Start = 1'b0; bus2.Accumulate = 1'b0; bus2.OpA = '0; bus2.OpB = '0; bus2.Addend = '0; bus2.Abort = 1'b0;
    reset = 1'b0;
    #3;
    chkResetOutputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();

    // Table-driven MUL/MLA on the BPC=1 engine.
    foreach (vecs[k]) begin
      startOp1(vecs[k].acc, vecs[k].a, vecs[k].b, vecs[k].add);
      @(negedge clk);
      chk($sformatf("v%0d_stall_c0", k), 32'(bus1.StallMul), 32'd1);
      nextCycle();
      bus1.Start = 1'b0;
      waitDone1(lat, ok);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
      chk($sformatf("v%0d_stall_run", k), 32'(ok), 32'd1);
      chk($sformatf("v%0d_result", k), bus1.Result, vecs[k].res);
      chk($sformatf("v%0d_resn", k), 32'(bus1.ResN), 32'(vecs[k].n));
      chk($sformatf("v%0d_resz", k), 32'(bus1.ResZ), 32'(vecs[k].z));
      chk($sformatf("v%0d_stall_done", k), 32'(bus1.StallMul), 32'd0);
      chk($sformatf("v%0d_busy_done", k), 32'(bus1.Busy), 32'd0);
      nextCycle();
      @(negedge clk);
      chk($sformatf("v%0d_done_once", k), 32'(bus1.Done), 32'd0);
      chk($sformatf("v%0d_result_hold", k), bus1.Result, vecs[k].res);
      nextCycle();
    end

    // Abort in cycle 10 of RUN; Result keeps the previous value (1).
    startOp1(1'b0, 32'd9, 32'd9, 32'd0);
    nextCycle();
    bus1.Start = 1'b0;
    repeat (9) nextCycle();
    bus1.Abort = 1'b1;
    @(negedge clk);
    chk("abort_busy_c10", 32'(bus1.Busy), 32'd1);
    nextCycle();
    bus1.Abort = 1'b0;
    @(negedge clk);
    chk("abort_stall_c11", 32'(bus1.StallMul), 32'd0);
    chk("abort_busy_c11", 32'(bus1.Busy), 32'd0);
    chk("abort_result", bus1.Result, 32'd1);
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      nextCycle();
      @(negedge clk);
      if (bus1.Done) doneCnt++;
    end
    chk("abort_no_done", 32'(doneCnt), 32'd0);
    nextCycle();

    // Start and Abort together in IDLE.
    bus1.Start = 1'b1;
    bus1.Abort = 1'b1;
    @(negedge clk);
    chk("startabort_stall", 32'(bus1.StallMul), 32'd0);
    nextCycle();
    bus1.Start = 1'b0;
    bus1.Abort = 1'b0;
    @(negedge clk);
    chk("startabort_busy", 32'(bus1.Busy), 32'd0);
    nextCycle();

    // Back-to-back: Start held during the DONE cycle.
    startOp1(1'b0, 32'd7, 32'd6, 32'd0);
    nextCycle();
    bus1.Start = 1'b0;
    waitDone1(lat, ok);
    chk("b2b_first_result", bus1.Result, 32'd42);
    startOp1(1'b0, 32'd3, 32'd5, 32'd0);
    #1;
    chk("b2b_stall_in_done", 32'(bus1.StallMul), 32'd1);
    nextCycle();
    bus1.Start = 1'b0;
    waitDone1(lat2, ok);
    chk("b2b_gap", 32'(lat2), 32'd33);
    chk("b2b_second_result", bus1.Result, 32'd15);
    nextCycle();

    // Early-exit engine, BPC=4.
    foreach (evecs[k]) begin
      bus2.Start = 1'b1;
      bus2.OpA   = evecs[k].a;
      bus2.OpB   = evecs[k].b;
      nextCycle();
      bus2.Start = 1'b0;
      waitDone2(lat);
      chk($sformatf("e%0d_latency", k), 32'(lat), 32'(evecs[k].lat));
      chk($sformatf("e%0d_result", k), bus2.Result, evecs[k].res);
      nextCycle();
    end

    // Asynchronous reset while both engines are in RUN.
    startOp1(1'b0, 32'd3, 32'd5, 32'd0);
    bus2.Start = 1'b1;
    bus2.OpA   = 32'd1;
    bus2.OpB   = 32'hFFFFFFFF;
    nextCycle();
    bus1.Start = 1'b0;
    bus2.Start = 1'b0;
    nextCycle();
    @(negedge clk);
    chk("midrun_busy1", 32'(bus1.Busy), 32'd1);
    chk("midrun_busy2", 32'(bus2.Busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chkResetOutputs("arst");
    @(negedge clk);
    reset = 1'b1;
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative shift-add multiply engine with its sequencing FSM, serving MUL/MLA in the pipelined core's Execute stage. The pipeline presents operands and a start strobe. The block stalls Fetch/Decode/Execute while it iterates, then presents a WIDTH-bit result plus N/Z flags for one cycle as the pipeline resumes. It replaces the single-cycle multiply path, so the ALU no longer needs a WIDTH x WIDTH array.

Parameters:
WIDTH, 32, operand and result width in bits.
BPC, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4; WIDTH mod BPC = 0.
EARLY_EXIT, 0, 1 = leave RUN as soon as the remaining multiplier bits are all zero.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Start  in  1  request multiply; driven by MulOpE gated with CondExE.
Accumulate  in  1  1 = MLA (add Addend), 0 = MUL; sampled with Start.
OpA  in  WIDTH  multiplicand (Rm); sampled with Start.
OpB  in  WIDTH  multiplier (Rs); sampled with Start.
Addend  in  WIDTH  accumulate operand (Ra); sampled with Start.
Abort  in  1  synchronous cancel (FlushE); kills the operation in flight.
StallMul  out  1  hold F/D/E stages and bubble M.
Busy  out  1  state is RUN or ACC.
Done  out  1  one-cycle strobe; Result and flags are valid.
Result  out  WIDTH  low WIDTH bits of OpA*OpB (+Addend).
ResN  out  1  Result[WIDTH-1].
ResZ  out  1  Result == 0.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; StallMul=0, Busy=0, Done=0; Result=0; ResN=0, ResZ=1; internal registers cleared.
- FSM states: IDLE, RUN, ACC, DONE.
- IDLE: Start=1 and Abort=0 latches the operands and Accumulate, sets P=0, sets cnt=WIDTH/BPC-1, and goes to RUN. StallMul is asserted combinationally in the Start cycle.
- RUN: each cycle P += (M_A * mulB[BPC-1:0]) mod 2^WIDTH, then M_A <<= BPC and mulB >>= BPC.
  - When cnt==0, or when EARLY_EXIT=1 and the updated mulB==0, go to ACC if Accumulate else DONE.
  - Otherwise decrement cnt.
- ACC: P += Addend (mod 2^WIDTH), then go to DONE.
- DONE: Done=1 and StallMul=0 for exactly one cycle. Result and flags update on entry and hold until the next DONE.
  - Start=1 in DONE is accepted back-to-back: go to RUN, with StallMul asserted that cycle.
  - Otherwise go to IDLE.
- StallMul = (IDLE|DONE)&Start&~Abort | RUN | ACC.
- Busy = RUN | ACC.
- Latency, with N = WIDTH/BPC and Start in cycle 0: Done in cycle N+1 (MUL) or N+2 (MLA). EARLY_EXIT can shorten RUN to ceil((msb_index(OpB)+1)/BPC) cycles, minimum 1.
- Start while in RUN/ACC is ignored. The pipeline cannot issue it, because the block is stalling.
- Abort from any state: next state IDLE, no Done, Result unchanged. Abort outranks Start in the same cycle.
- Arithmetic: unsigned shift-add. The low WIDTH bits are sign-agnostic. All overflow wraps modulo 2^WIDTH.
- OpB==0: the full RUN length still applies when EARLY_EXIT=0.
- Asynchronous reset mid-operation: immediate return to IDLE; outputs return to their reset values.

Test Plan:
- MUL, OpA=7, OpB=6, Start in cycle 0 -> StallMul=1 in cycles 0..32; Done=1 in cycle 33 only; Result=42, ResN=0, ResZ=0.
- MLA, OpA=0xFFFFFFFF, OpB=2, Addend=3 -> Done in cycle 34; Result=0x00000001 (wrap).
- MUL, OpA=0x80000000, OpB=1 -> Result=0x80000000, ResN=1; then OpA=0x10000, OpB=0x10000 -> Result=0, ResZ=1.
- Abort asserted in cycle 10 of a RUN -> IDLE in cycle 11; StallMul=0, no Done; Result keeps the prior value. A simultaneous Start and Abort in IDLE -> stays IDLE.
- Back-to-back: Start held in the DONE cycle with OpA=3, OpB=5 -> the first Done is seen, RUN re-entered immediately; the second Done shows 15 and is 33 cycles after the first.
- EARLY_EXIT=1, BPC=4, OpB=0x5 -> 1 RUN cycle; Done in cycle 2. reset pulled low mid-RUN -> all outputs at reset values asynchronously; ResZ=1.
